// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings and FSM state types for the slave RAM.
package axi4_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
    typedef enum logic {R_IDLE, R_DATA} rd_state_e;

    // WRAP is handled as INCR; only FIXED holds the index.
    function automatic logic burst_advances(input logic [1:0] burst);
        unique case (burst)
            BURST_FIXED:            return 1'b0;
            BURST_INCR, BURST_WRAP: return 1'b1;
            default:                return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/axi4_slave_ram_mem.sv
// Word-organised RAM with a byte-enabled synchronous write port and asynchronous read port.
module axi4_slave_ram_mem #(
    parameter int unsigned AddrWidth = 10,
    parameter int unsigned DataWidth = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [AddrWidth-1:0]     waddr,
    input  logic [DataWidth-1:0]     wdata,
    input  logic [DataWidth/8-1:0]   wstrb,
    input  logic [AddrWidth-1:0]     raddr,
    output logic [DataWidth-1:0]     rdata
);

    localparam int unsigned Depth = 1 << AddrWidth;

    logic [DataWidth-1:0] mem [Depth];

    // No reset: contents survive ARESET.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DataWidth / 8; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axi4_slave_ram.sv
// AXI4 full slave backed by on-chip RAM: independent write and read FSMs, INCR/FIXED bursts.
module axi4_slave_ram
    import axi4_pkg::*;
#(
    parameter int unsigned C_S_AXI_ID_WIDTH   = 1,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_MEM_WORDS_LOG2   = 10
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]                      S_AXI_AWLEN,
    input  logic [2:0]                      S_AXI_AWSIZE,
    input  logic [1:0]                      S_AXI_AWBURST,
    input  logic                            S_AXI_AWLOCK,
    input  logic [3:0]                      S_AXI_AWCACHE,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic [3:0]                      S_AXI_AWQOS,
    input  logic                            S_AXI_AWUSER,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WLAST,
    input  logic                            S_AXI_WUSER,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BUSER,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]                      S_AXI_ARLEN,
    input  logic [2:0]                      S_AXI_ARSIZE,
    input  logic [1:0]                      S_AXI_ARBURST,
    input  logic                            S_AXI_ARLOCK,
    input  logic [3:0]                      S_AXI_ARCACHE,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic [3:0]                      S_AXI_ARQOS,
    input  logic                            S_AXI_ARUSER,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RLAST,
    output logic                            S_AXI_RUSER,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);

    localparam int unsigned StrbWidth = C_S_AXI_DATA_WIDTH / 8;
    localparam int unsigned OffWidth  = $clog2(StrbWidth);
    localparam int unsigned IdxWidth  = C_MEM_WORDS_LOG2;

    // ---------------- write channel ----------------
    wr_state_e                   w_state_q, w_state_d;
    logic [C_S_AXI_ID_WIDTH-1:0] w_id_q, w_id_d;
    logic [IdxWidth-1:0]         w_idx_q, w_idx_d;
    logic [7:0]                  w_len_q, w_len_d;
    logic [7:0]                  w_beat_q, w_beat_d;
    logic [1:0]                  w_burst_q, w_burst_d;
    logic                        w_err_q, w_err_d;
    logic                        aw_ready, w_ready, b_valid, mem_we, w_last_beat;

    assign w_last_beat = (w_beat_q == w_len_q);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_idx_q   <= '0;
            w_len_q   <= '0;
            w_beat_q  <= '0;
            w_burst_q <= BURST_INCR;
            w_err_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_idx_q   <= w_idx_d;
            w_len_q   <= w_len_d;
            w_beat_q  <= w_beat_d;
            w_burst_q <= w_burst_d;
            w_err_q   <= w_err_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_beat_d  = w_beat_q;
        w_burst_d = w_burst_q;
        w_err_d   = w_err_q;
        aw_ready  = 1'b0;
        w_ready   = 1'b0;
        b_valid   = 1'b0;
        mem_we    = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                aw_ready = 1'b1;
                if (S_AXI_AWVALID) begin
                    w_id_d    = S_AXI_AWID;
                    w_idx_d   = S_AXI_AWADDR[OffWidth +: IdxWidth];
                    w_len_d   = S_AXI_AWLEN;
                    w_burst_d = S_AXI_AWBURST;
                    w_beat_d  = 8'd0;
                    w_err_d   = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                w_ready = 1'b1;
                if (S_AXI_WVALID) begin
                    mem_we   = 1'b1;
                    w_beat_d = w_beat_q + 8'd1;
                    if (burst_advances(w_burst_q)) begin
                        w_idx_d = w_idx_q + IdxWidth'(1);
                    end
                    // Burst ends on WLAST or on the final beat; disagreement is a protocol error.
                    if (S_AXI_WLAST || w_last_beat) begin
                        w_err_d   = w_err_q | (S_AXI_WLAST != w_last_beat);
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                b_valid = 1'b1;
                if (S_AXI_BREADY) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // ---------------- read channel ----------------
    rd_state_e                   r_state_q, r_state_d;
    logic [C_S_AXI_ID_WIDTH-1:0] r_id_q, r_id_d;
    logic [IdxWidth-1:0]         r_idx_q, r_idx_d;
    logic [7:0]                  r_len_q, r_len_d;
    logic [7:0]                  r_beat_q, r_beat_d;
    logic [1:0]                  r_burst_q, r_burst_d;
    logic                        ar_ready, r_valid, r_last_beat;

    assign r_last_beat = (r_beat_q == r_len_q);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_beat_q  <= '0;
            r_burst_q <= BURST_INCR;
        end else begin
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_idx_q   <= r_idx_d;
            r_len_q   <= r_len_d;
            r_beat_q  <= r_beat_d;
            r_burst_q <= r_burst_d;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_beat_d  = r_beat_q;
        r_burst_d = r_burst_q;
        ar_ready  = 1'b0;
        r_valid   = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
                ar_ready = 1'b1;
                if (S_AXI_ARVALID) begin
                    r_id_d    = S_AXI_ARID;
                    r_idx_d   = S_AXI_ARADDR[OffWidth +: IdxWidth];
                    r_len_d   = S_AXI_ARLEN;
                    r_burst_d = S_AXI_ARBURST;
                    r_beat_d  = 8'd0;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                r_valid = 1'b1;
                if (S_AXI_RREADY) begin
                    if (r_last_beat) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_beat_d = r_beat_q + 8'd1;
                        if (burst_advances(r_burst_q)) begin
                            r_idx_d = r_idx_q + IdxWidth'(1);
                        end
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    axi4_slave_ram_mem #(
        .AddrWidth (IdxWidth),
        .DataWidth (C_S_AXI_DATA_WIDTH)
    ) u_mem (
        .clk   (ACLK),
        .we    (mem_we),
        .waddr (w_idx_q),
        .wdata (S_AXI_WDATA),
        .wstrb (S_AXI_WSTRB),
        .raddr (r_idx_q),
        .rdata (S_AXI_RDATA)
    );

    assign S_AXI_AWREADY = aw_ready;
    assign S_AXI_WREADY  = w_ready;
    assign S_AXI_BVALID  = b_valid;
    assign S_AXI_BID     = w_id_q;
    assign S_AXI_BRESP   = (b_valid && w_err_q) ? RESP_SLVERR : RESP_OKAY;
    assign S_AXI_BUSER   = 1'b0;
    assign S_AXI_ARREADY = ar_ready;
    assign S_AXI_RVALID  = r_valid;
    assign S_AXI_RID     = r_id_q;
    assign S_AXI_RRESP   = RESP_OKAY;
    assign S_AXI_RLAST   = r_valid && r_last_beat;
    assign S_AXI_RUSER   = 1'b0;

    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWSIZE, S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT,
                             S_AXI_AWQOS, S_AXI_AWUSER, S_AXI_WUSER, S_AXI_AWADDR,
                             S_AXI_ARSIZE, S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT,
                             S_AXI_ARQOS, S_AXI_ARUSER, S_AXI_ARADDR,
                             RESP_EXOKAY, RESP_DECERR};

endmodule
